// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS control path: opcodes, ALUOp codes,
// FSM state encodings. Optional jump support is enabled with MULTICYCLE_JUMP_EN.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALUOP_ADD   = 3'b000;
  localparam logic [2:0] ALUOP_BEQ   = 3'b001;
  localparam logic [2:0] ALUOP_RTYPE = 3'b010;
  localparam logic [2:0] ALUOP_ADDI  = 3'b011;
  localparam logic [2:0] ALUOP_SLTI  = 3'b100;
  localparam logic [2:0] ALUOP_BNE   = 3'b101;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_REXEC  = 4'd6,
    S_RWB    = 4'd7,
    S_BEQ    = 4'd8,
    S_BNE    = 4'd9,
    S_IEXEC  = 4'd10,
    S_IWB    = 4'd11
`ifdef MULTICYCLE_JUMP_EN
    ,S_JUMP  = 4'd12
`endif
  } state_t;

  typedef struct packed {
    logic       pcwrite;
    logic       pcwritecond;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       memtoreg;
    logic       irwrite;
    logic       alusrca;
    logic       regwrite;
    logic       regdst;
    logic [1:0] pcsource;
    logic [1:0] alusrcb;
    logic [2:0] aluop;
  } ctrl_t;

  // DECODE dispatch; unsupported opcodes fall back to FETCH.
  function automatic state_t decode_next(input logic [5:0] op);
    state_t s;
    case (op)
      OP_RTYPE:        s = S_REXEC;
      OP_LW, OP_SW:    s = S_MEMADR;
      OP_BEQ:          s = S_BEQ;
      OP_BNE:          s = S_BNE;
      OP_ADDI, OP_SLTI: s = S_IEXEC;
`ifdef MULTICYCLE_JUMP_EN
      OP_J:            s = S_JUMP;
`endif
      default:         s = S_FETCH;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/multicycle_control_outdec.sv
// Output decoder: state (plus OpReg, MemReady) to datapath strobes and selects.
// Reset forces every output low. JUMP decode is present only with MULTICYCLE_JUMP_EN.
module multicycle_control_outdec
  import mips_ctrl_pkg::*;
(
  input  logic       rst,
  input  state_t     state,
  input  logic [5:0] opreg,
  input  logic       mem_ready,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    if (!rst) begin
      case (state)
        S_FETCH: begin
          ctrl.memread = 1'b1;
          ctrl.alusrcb = 2'b01;
          ctrl.aluop   = ALUOP_ADD;
          // IR and PC update only when the fetch actually completes
          ctrl.irwrite = mem_ready;
          ctrl.pcwrite = mem_ready;
        end
        S_DECODE: begin
          ctrl.alusrcb = 2'b11;
          ctrl.aluop   = ALUOP_ADD;
        end
        S_MEMADR: begin
          ctrl.alusrca = 1'b1;
          ctrl.alusrcb = 2'b10;
          ctrl.aluop   = ALUOP_ADD;
        end
        S_MEMRD: begin
          ctrl.iord    = 1'b1;
          ctrl.memread = 1'b1;
        end
        S_MEMWB: begin
          ctrl.regwrite = 1'b1;
          ctrl.memtoreg = 1'b1;
        end
        S_MEMWR: begin
          ctrl.iord     = 1'b1;
          ctrl.memwrite = 1'b1;
        end
        S_REXEC: begin
          ctrl.alusrca = 1'b1;
          ctrl.aluop   = ALUOP_RTYPE;
        end
        S_RWB: begin
          ctrl.regwrite = 1'b1;
          ctrl.regdst   = 1'b1;
        end
        S_BEQ, S_BNE: begin
          ctrl.alusrca     = 1'b1;
          ctrl.pcwritecond = 1'b1;
          ctrl.pcsource    = 2'b01;
          ctrl.aluop       = (state == S_BNE) ? ALUOP_BNE : ALUOP_BEQ;
        end
        S_IEXEC: begin
          ctrl.alusrca = 1'b1;
          ctrl.alusrcb = 2'b10;
          ctrl.aluop   = (opreg == OP_SLTI) ? ALUOP_SLTI : ALUOP_ADDI;
        end
        S_IWB: ctrl.regwrite = 1'b1;
`ifdef MULTICYCLE_JUMP_EN
        S_JUMP: begin
          ctrl.pcwrite  = 1'b1;
          ctrl.pcsource = 2'b10;
        end
`endif
        default: ctrl = '0;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS main control FSM: state register, OpReg and next-state logic.
// Define MULTICYCLE_JUMP_EN to support the j instruction (opcode 000010).
module multicycle_control
  import mips_ctrl_pkg::*;
(
  input  logic       Clock,
  input  logic       Reset,
  input  logic [5:0] Op,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       IRWrite,
  output logic       ALUSrcA,
  output logic       RegWrite,
  output logic       RegDst,
  output logic [1:0] PCSource,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUOp,
  output logic       IllegalOp,
  output logic [3:0] State
);

  state_t     state, state_nxt;
  logic [5:0] opreg;
  logic       illegal;
  ctrl_t      ctrl;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= S_FETCH;
      opreg <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_DECODE) opreg <= Op;
    end
  end

  always_comb begin
    state_nxt = S_FETCH;
    illegal   = 1'b0;
    case (state)
      S_FETCH:  state_nxt = MemReady ? S_DECODE : S_FETCH;
      S_DECODE: begin
        state_nxt = decode_next(Op);
        illegal   = (state_nxt == S_FETCH);
      end
      S_MEMADR: state_nxt = (opreg == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_nxt = MemReady ? S_MEMWB : S_MEMRD;
      S_MEMWR:  state_nxt = MemReady ? S_FETCH : S_MEMWR;
      S_REXEC:  state_nxt = S_RWB;
      S_IEXEC:  state_nxt = S_IWB;
      default:  state_nxt = S_FETCH;
    endcase
  end

  multicycle_control_outdec u_outdec (
    .rst       (Reset),
    .state     (state),
    .opreg     (opreg),
    .mem_ready (MemReady),
    .ctrl      (ctrl)
  );

  assign PCWrite     = ctrl.pcwrite;
  assign PCWriteCond = ctrl.pcwritecond;
  assign IorD        = ctrl.iord;
  assign MemRead     = ctrl.memread;
  assign MemWrite    = ctrl.memwrite;
  assign MemtoReg    = ctrl.memtoreg;
  assign IRWrite     = ctrl.irwrite;
  assign ALUSrcA     = ctrl.alusrca;
  assign RegWrite    = ctrl.regwrite;
  assign RegDst      = ctrl.regdst;
  assign PCSource    = ctrl.pcsource;
  assign ALUSrcB     = ctrl.alusrcb;
  assign ALUOp       = ctrl.aluop;
  assign IllegalOp   = illegal & ~Reset;
  assign State       = Reset ? 4'd0 : state;

endmodule
